// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for uart_tx_arbiter.
// The master side is the requesters plus the UART transmitter; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_req;
  logic                    tx_ack;
  logic                    grant_valid;
  logic [GID_W-1:0]        grant_id;
  logic                    timeout_evt;

  modport master (
    output req_valid, req_data, req_last, tx_ack,
    input  req_ready, tx_data, tx_req, grant_valid, grant_id, timeout_evt
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ack,
    output req_ready, tx_data, tx_req, grant_valid, grant_id, timeout_evt
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter through a one-byte holding register.
// Optional stalled-grant revocation is enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.slave    bus
);
  localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t              r_state;
  logic [GID_W-1:0]    r_grant_id;
  logic [GID_W-1:0]    r_last_grant;
  logic                r_grant_valid;
  logic                r_hold_full;
  logic                r_hold_last;
  logic [DATA_W-1:0]   r_hold_data;

  logic [N_REQ-1:0]    w_ready;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_accept;
  logic                w_pop;
  logic [GID_W-1:0]    w_pick;
  logic                w_tmo_fire;

  // Scan last+1, last+2, ... with explicit wrap so non-power-of-two N_REQ works.
  function automatic logic [GID_W-1:0] f_next_grant(input logic [GID_W-1:0] last,
                                                    input logic [N_REQ-1:0] valid);
    logic [GID_W-1:0] idx;
    logic [GID_W-1:0] pick;
    logic             found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (idx == GID_W'(N_REQ-1)) idx = '0;
      else                        idx = idx + GID_W'(1);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    w_ready = '0;
    if (r_state == S_XFER && !r_hold_full) w_ready[r_grant_id] = 1'b1;
  end

  assign w_sel_valid = bus.req_valid[r_grant_id];
  assign w_sel_last  = bus.req_last[r_grant_id];
  assign w_sel_data  = bus.req_data[int'(r_grant_id)*DATA_W +: DATA_W];
  assign w_accept    = w_sel_valid & w_ready[r_grant_id];
  assign w_pop       = bus.tx_ack & r_hold_full;
  assign w_pick      = f_next_grant(r_last_grant, bus.req_valid);

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout_evt;
  logic             w_tmo_idle;

  // Only an empty holding register counts as stalled, so a pending byte is never dropped.
  assign w_tmo_idle = (r_state == S_XFER) && !r_hold_full && !w_sel_valid;
  assign w_tmo_fire = w_tmo_idle && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= '0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_timeout_evt <= w_tmo_fire;
      if (r_state != S_XFER || w_accept || w_tmo_fire) r_tmo_cnt <= '0;
      else if (w_tmo_idle)                             r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign bus.timeout_evt = r_timeout_evt;
`else
  assign w_tmo_fire      = 1'b0;
  assign bus.timeout_evt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant_id    <= '0;
      r_last_grant  <= GID_W'(N_REQ - 1);
      r_grant_valid <= 1'b0;
      r_hold_full   <= 1'b0;
      r_hold_last   <= 1'b0;
      r_hold_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            r_grant_id    <= w_pick;
            r_grant_valid <= 1'b1;
            r_state       <= S_XFER;
          end
        end
        S_XFER: begin
          // Pop and accept are exclusive: ready is held low while the register is full.
          if (w_pop) begin
            r_hold_full <= 1'b0;
            if (r_hold_last) begin
              r_last_grant  <= r_grant_id;
              r_grant_valid <= 1'b0;
              r_state       <= S_IDLE;
            end
          end else if (w_accept) begin
            r_hold_data <= w_sel_data;
            r_hold_last <= w_sel_last;
            r_hold_full <= 1'b1;
          end else if (w_tmo_fire) begin
            r_last_grant  <= r_grant_id;
            r_grant_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.tx_data     = r_hold_data;
  assign bus.tx_req      = r_hold_full;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_id    = r_grant_id;
endmodule
